// File: rtl/octal_display_scheduler_pkg.sv
// Shared types and constants for the octal display scheduler.
//   scheduler_state_t : idle / converting / done-pulse states
//   SEG_BLANK         : active-low pattern with every segment off
package octal_display_pkg;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} scheduler_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/octal_display_scheduler_if.sv
// Request handshake between a datapath result register and the scheduler.
//   value_i    : packed octal word, digit k at [3k+2:3k]
//   valid_i    : request to display value_i
//   blank_en_i : leading-zero blanking enable, sampled with the request
//   ready_o    : scheduler can accept a request this cycle
// master = requester, slave = scheduler.
interface octal_display_scheduler_if #(
    parameter int NUM_DIGITS = 8
);
    logic [3*NUM_DIGITS-1:0] value_i;
    logic                    valid_i;
    logic                    blank_en_i;
    logic                    ready_o;

    modport master (output value_i, output valid_i, output blank_en_i, input ready_o);
    modport slave  (input value_i, input valid_i, input blank_en_i, output ready_o);
endinterface

// File: rtl/convert_octal_to_seven_segment.sv
// Combinational octal digit to active-low seven-segment decoder.
//   digit_i : octal digit 0..7
//   seg_o   : segment pattern, bit 6 = g ... bit 0 = a, 0 = segment lit
module convert_octal_to_seven_segment (
    input  logic [2:0] digit_i,
    output logic [6:0] seg_o
);

    // Straight lookup of the eight glyphs.
    always_comb begin
        case (digit_i)
            3'd0:    seg_o = 7'b1000000;
            3'd1:    seg_o = 7'b1111001;
            3'd2:    seg_o = 7'b0100100;
            3'd3:    seg_o = 7'b0110000;
            3'd4:    seg_o = 7'b0011001;
            3'd5:    seg_o = 7'b0010010;
            3'd6:    seg_o = 7'b0000010;
            default: seg_o = 7'b1111000;
        endcase
    end

endmodule

// File: rtl/octal_display_scheduler.sv
// Time-shares one octal-to-seven-segment converter across NUM_DIGITS
// registered display outputs. A request is accepted in S_IDLE, then digits
// are converted most significant first, CYCLES_PER_DIGIT cycles per digit.
//   clock, reset : system clock, synchronous active-high reset
//   req          : request handshake (slave side)
//   seven_seg_o  : registered active-low patterns, index k drives display k
//   done_o       : one-cycle pulse after the last digit is written
module octal_display_scheduler
    import octal_display_pkg::*;
#(
    parameter int NUM_DIGITS       = 8,
    parameter int CYCLES_PER_DIGIT = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    octal_display_scheduler_if.slave    req,
    output logic [NUM_DIGITS-1:0][6:0]  seven_seg_o,
    output logic                        done_o
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(CYCLES_PER_DIGIT) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_DIGIT - 1);

    scheduler_state_t             state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         lead_q, lead_d;
    logic                         blank_q, blank_d;
    logic [3*NUM_DIGITS-1:0]      value_q, value_d;
    logic [NUM_DIGITS-1:0][6:0]   seg_q, seg_d;

    logic [2:0] curDigit;
    logic [6:0] convPattern;
    logic       slotDone;
    logic       blankThis;

    assign curDigit  = value_q[3*idx_q +: 3];
    assign slotDone  = (state_q == S_CONVERT) && (cnt_q == CNT_LAST);
    // Only zeros still in the leading run are blanked; digit 0 always shows.
    assign blankThis = blank_q && lead_q && (curDigit == 3'd0) && (idx_q != '0);

    convert_octal_to_seven_segment u_conv (
        .digit_i (curDigit),
        .seg_o   (convPattern)
    );

    // State and datapath registers; reset blanks the whole bank.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            lead_q  <= 1'b0;
            blank_q <= 1'b0;
            value_q <= '0;
            seg_q   <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            lead_q  <= lead_d;
            blank_q <= blank_d;
            value_q <= value_d;
            seg_q   <= seg_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req.valid_i) state_d = S_CONVERT;
            S_CONVERT: if (slotDone && (idx_q == '0)) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath next values: latch on accept, write one digit per slot.
    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        lead_d  = lead_q;
        blank_d = blank_q;
        value_d = value_q;
        seg_d   = seg_q;
        if ((state_q == S_IDLE) && req.valid_i) begin
            value_d = req.value_i;
            blank_d = req.blank_en_i;
            idx_d   = LAST_IDX;
            lead_d  = 1'b1;
            cnt_d   = '0;
        end else if (state_q == S_CONVERT) begin
            if (slotDone) begin
                seg_d[idx_q] = blankThis ? SEG_BLANK : convPattern;
                if (curDigit != 3'd0) lead_d = 1'b0;
                // At idx 0 the FSM leaves S_CONVERT, so idx and cnt never wrap.
                if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                    cnt_d = '0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        req.ready_o = (state_q == S_IDLE);
        done_o      = (state_q == S_DONE);
        seven_seg_o = seg_q;
    end

endmodule

// File: tb/tb_octal_display_scheduler.sv
// Self-checking bench: a default-sized instance (8 digits, 1 cycle/digit)
// and a paced instance (4 digits, 3 cycles/digit) share clock and reset.
module tb_octal_display_scheduler;
    import octal_display_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [23:0] reqValue = '0;
    logic        reqBlank = 1'b0;
    logic        validA   = 1'b0;
    logic        validB   = 1'b0;

    octal_display_scheduler_if #(.NUM_DIGITS(8)) ifA ();
    octal_display_scheduler_if #(.NUM_DIGITS(4)) ifB ();

    assign ifA.value_i    = reqValue;
    assign ifA.valid_i    = validA;
    assign ifA.blank_en_i = reqBlank;
    assign ifB.value_i    = reqValue[11:0];
    assign ifB.valid_i    = validB;
    assign ifB.blank_en_i = reqBlank;

    logic [55:0] bankA;
    logic        doneA;
    logic [27:0] bankB;
    logic        doneB;

    octal_display_scheduler #(.NUM_DIGITS(8), .CYCLES_PER_DIGIT(1)) dutA (
        .clock       (clock),
        .reset       (reset),
        .req         (ifA.slave),
        .seven_seg_o (bankA),
        .done_o      (doneA)
    );

    octal_display_scheduler #(.NUM_DIGITS(4), .CYCLES_PER_DIGIT(3)) dutB (
        .clock       (clock),
        .reset       (reset),
        .req         (ifB.slave),
        .seven_seg_o (bankB),
        .done_o      (doneB)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [6:0] segCode [8];

    typedef struct {
        logic [23:0] value;
        logic        blank;
        logic [55:0] expBank;
        string       name;
    } vec_t;
    vec_t vecs [4];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Final bank from the display rules: walk digits MS first, blank zeros
    // while still in the leading run (never digit 0).
    function automatic logic [55:0] modelBank(input logic [23:0] v, input bit b, input int nd);
        logic [55:0] r = '0;
        bit lead = 1'b1;
        int d;
        for (int k = nd - 1; k >= 0; k--) begin
            d = int'((v >> (3 * k)) & 24'd7);
            if (b && lead && d == 0 && k != 0) r[7*k +: 7] = SEG_BLANK;
            else r[7*k +: 7] = segCode[d];
            if (d != 0) lead = 1'b0;
        end
        return r;
    endfunction

    // Handshake one request and check ready/done timing; returns at the
    // negedge of the first idle cycle after done.
    task automatic applyStimulus(input bit useB, input logic [23:0] v, input bit b, input string tag);
        int  lat = useB ? 13 : 9;
        int  doneAt = -1;
        int  pulses = 0;
        bit  readyBad = 1'b0;
        bit  readyBack = 1'b0;
        bit  accepted = 1'b0;
        logic rdy, dn;
        @(negedge clock);
        reqValue = v;
        reqBlank = b;
        if (useB) validB = 1'b1; else validA = 1'b1;
        for (int g = 0; g < 40 && !accepted; g++) begin
            if (useB ? ifB.ready_o : ifA.ready_o) accepted = 1'b1;
            else @(negedge clock);
        end
        checkOutput({tag, " accept"}, 64'(accepted), 64'd1);
        if (!accepted) begin
            validA = 1'b0;
            validB = 1'b0;
            return;
        end
        @(negedge clock);
        validA = 1'b0;
        validB = 1'b0;
        for (int n = 1; n <= lat + 1; n++) begin
            rdy = useB ? ifB.ready_o : ifA.ready_o;
            dn  = useB ? doneB : doneA;
            if (n <= lat && rdy) readyBad = 1'b1;
            if (n == lat + 1) readyBack = rdy;
            if (dn) begin
                pulses++;
                if (doneAt < 0) doneAt = n;
            end
            if (n <= lat) @(negedge clock);
        end
        checkOutput({tag, " done cycle"}, 64'(doneAt), 64'(lat));
        checkOutput({tag, " done pulses"}, 64'(pulses), 64'd1);
        checkOutput({tag, " ready low while busy"}, 64'(readyBad), 64'd0);
        checkOutput({tag, " ready back"}, 64'(readyBack), 64'd1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [55:0] expA;
        logic [55:0] finalB;
        logic [27:0] expB;
        logic [23:0] rv;
        bit rb, found, sawDone;
        int w;

        segCode[0] = 7'b1000000; segCode[1] = 7'b1111001;
        segCode[2] = 7'b0100100; segCode[3] = 7'b0110000;
        segCode[4] = 7'b0011001; segCode[5] = 7'b0010010;
        segCode[6] = 7'b0000010; segCode[7] = 7'b1111000;

        vecs[0] = '{value: 24'o12345670, blank: 1'b0, name: "full decode",
                    expBank: {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h40}};
        vecs[1] = '{value: 24'o00000305, blank: 1'b1, name: "lead blank",
                    expBank: {{5{7'h7F}}, 7'h30, 7'h40, 7'h12}};
        vecs[2] = '{value: 24'o0, blank: 1'b1, name: "zero blank",
                    expBank: {{7{7'h7F}}, 7'h40}};
        vecs[3] = '{value: 24'o0, blank: 1'b0, name: "zero noblank",
                    expBank: {8{7'h40}}};

        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkOutput("reset readyA", 64'(ifA.ready_o), 64'd1);
        checkOutput("reset doneA", 64'(doneA), 64'd0);
        checkOutput("reset bankA", 64'(bankA), 64'({8{7'h7F}}));
        checkOutput("reset bankB", 64'(bankB), 64'({4{7'h7F}}));

        // Directed table
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, vecs[i].value, vecs[i].blank, vecs[i].name);
            checkOutput({vecs[i].name, " bank"}, 64'(bankA), 64'(vecs[i].expBank));
        end

        // Busy rejection and back-to-back acceptance
        @(negedge clock);
        reqValue = 24'o77777777;
        reqBlank = 1'b0;
        validA   = 1'b1;
        checkOutput("busy first ready", 64'(ifA.ready_o), 64'd1);
        @(negedge clock);
        reqValue = 24'o11111111;
        sawDone  = 1'b0;
        w        = 0;
        for (int n = 1; n <= 9; n++) begin
            if (ifA.ready_o) w++;
            if (n == 9) begin
                checkOutput("busy done at 9", 64'(doneA), 64'd1);
                checkOutput("busy first bank", 64'(bankA), 64'({8{7'h78}}));
            end
            @(negedge clock);
        end
        checkOutput("busy ready low count", 64'(w), 64'd0);
        checkOutput("busy second accept ready", 64'(ifA.ready_o), 64'd1);
        @(negedge clock);
        validA = 1'b0;
        found  = 1'b0;
        for (int g = 0; g < 20 && !found; g++) begin
            if (doneA) found = 1'b1;
            else @(negedge clock);
        end
        checkOutput("busy second done seen", 64'(found), 64'd1);
        checkOutput("busy second bank", 64'(bankA), 64'({8{7'h79}}));
        @(negedge clock);

        // Reset mid-conversion, with a simultaneous request
        @(negedge clock);
        reqValue = 24'o76543210;
        validA   = 1'b1;
        @(negedge clock);
        validA = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("partial MS digits", 64'(bankA[55:35]), 64'({7'h78, 7'h02, 7'h12}));
        checkOutput("partial LS kept", 64'(bankA[34:0]), 64'({5{7'h79}}));
        reset    = 1'b1;
        validA   = 1'b1;
        reqValue = 24'o12345670;
        @(negedge clock);
        reset  = 1'b0;
        validA = 1'b0;
        checkOutput("abort ready", 64'(ifA.ready_o), 64'd1);
        checkOutput("abort bank", 64'(bankA), 64'({8{7'h7F}}));
        sawDone = 1'b0;
        for (int n = 0; n < 15; n++) begin
            if (doneA) sawDone = 1'b1;
            @(negedge clock);
        end
        checkOutput("abort no done", 64'(sawDone), 64'd0);

        // Pacing on the 4-digit, 3-cycle instance (bank blank from reset)
        reqValue = 24'o4321;
        reqBlank = 1'b0;
        validB   = 1'b1;
        checkOutput("pace ready", 64'(ifB.ready_o), 64'd1);
        finalB = modelBank(24'o4321, 1'b0, 4);
        checkOutput("pace model", 64'(finalB), 64'({7'h19, 7'h30, 7'h24, 7'h79}));
        sawDone = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clock);
            validB = 1'b0;
            w = (n - 1) / 3;
            if (w > 4) w = 4;
            for (int k = 0; k < 4; k++)
                expB[7*k +: 7] = (k >= 4 - w) ? finalB[7*k +: 7] : SEG_BLANK;
            checkOutput($sformatf("pace bank c%0d", n), 64'(bankB), 64'(expB));
            if (doneB) begin
                checkOutput("pace done cycle", 64'(n), 64'd13);
                sawDone = 1'b1;
            end
        end
        checkOutput("pace done seen", 64'(sawDone), 64'd1);
        checkOutput("pace ready back", 64'(ifB.ready_o), 64'd1);

        // Randomised requests against the model
        for (int i = 0; i < 20; i++) begin
            rv = 24'($urandom) >> $urandom_range(0, 23);
            rb = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, rv, rb, $sformatf("randA%0d", i));
            expA = modelBank(rv, rb, 8);
            checkOutput($sformatf("randA%0d bank", i), 64'(bankA), 64'(expA));
        end
        for (int i = 0; i < 8; i++) begin
            rv = (24'($urandom) & 24'hFFF) >> $urandom_range(0, 11);
            rb = 1'($urandom_range(0, 1));
            applyStimulus(1'b1, rv, rb, $sformatf("randB%0d", i));
            expA = modelBank(rv, rb, 4);
            checkOutput($sformatf("randB%0d bank", i), 64'(bankB), 64'(expA));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
